// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses onto a word-only data memory,
// with read-modify-write for sub-word stores. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        wen,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, state_nxt;
   logic        wen_q, sext_q, mis_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, buf_q, rdata_q, wd_q;
   logic        mis_in;
   logic [1:0]  off;
   logic [4:0]  sh;
   logic [31:0] merged, lane, ext;

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis_in = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
   assign mis_in = 1'b0;
`endif

   // Lane offset forced to natural alignment so the untrapped build
   // silently uses the aligned halfword/word.
   always_comb begin
      off = 2'b00;
      case (size_q)
         2'b00:   off = addr_q[1:0];
         2'b01:   off = {addr_q[1], 1'b0};
         default: off = 2'b00;
      endcase
   end
   assign sh = {off, 3'b000};

   always_comb begin
      merged = buf_q;
      case (size_q)
         2'b00:   merged[sh +: 8]  = wdata_q[7:0];
         2'b01:   merged[sh +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      lane = mem_rd >> sh;
      ext  = mem_rd;
      case (size_q)
         2'b00:   ext = {{24{sext_q & lane[7]}}, lane[7:0]};
         2'b01:   ext = {{16{sext_q & lane[15]}}, lane[15:0]};
         default: ext = mem_rd;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req) begin
            if (mis_in)                state_nxt = RESP;
            else if (wen && size[1])   state_nxt = WR;
            else                       state_nxt = RD;
         end
         RD:      state_nxt = wen_q ? WR : RESP;
         WR:      state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         wen_q   <= 1'b0;
         sext_q  <= 1'b0;
         mis_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
         wd_q    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (req) begin
               wen_q   <= wen;
               sext_q  <= sext;
               mis_q   <= mis_in;
               size_q  <= size;
               addr_q  <= addr;
               wdata_q <= wdata;
            end
            RD: begin
               buf_q <= mem_rd;
               if (!wen_q) rdata_q <= ext;
            end
            WR:      wd_q <= merged;
            default: ;
         endcase
      end
   end

   // Outside WR the write port shows the last merged word.
   assign mem_wd   = (state == WR) ? merged : wd_q;
   assign mem_we   = (state == WR);
   assign mem_a    = {addr_q[31:2], 2'b00};
   assign busy     = (state != IDLE);
   assign done     = (state == RESP);
   assign misalign = (state == RESP) && mis_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for lsu with a word memory model;
// expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst_n, req, wen, sext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        busy, done, misalign, mem_we;
   logic [31:0] rdata, mem_a, mem_wd, mem_rd;

   logic [31:0] mem [0:63];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   lsu dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .size(size), .sext(sext),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
      .misalign(misalign), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_rd(mem_rd)
   );

   always @(posedge clk) begin
      if (pre_we)      mem[pre_idx] <= pre_val;
      else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
   end
   assign mem_rd = mem[mem_a[7:2]];

   typedef struct {
      logic        wen;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        poke;
      logic [31:0] exp_rd;
      int          exp_edges;
      int          exp_we;
      logic        exp_mis;
      logic [31:0] chk_addr;
      logic [31:0] exp_word;
   } vec_t;

   vec_t tv [14];

   function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd, input logic pk,
                               input logic [31:0] erd, input int ee, input int ewe,
                               input logic em, input logic [31:0] ca, input logic [31:0] ew);
      vec_t v;
      v.wen = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd; v.poke = pk;
      v.exp_rd = erd; v.exp_edges = ee; v.exp_we = ewe; v.exp_mis = em;
      v.chk_addr = ca; v.exp_word = ew;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Edges are counted from the accepting edge (1) to the edge entering RESP.
   task automatic run(input vec_t v, output int edges, output int wes,
                      output logic [31:0] rd, output logic mis);
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      req = 1'b1; wen = v.wen; size = v.size; sext = v.sext; addr = v.addr; wdata = v.wdata;
      edges = 0; wes = 0; rd = '0; mis = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (v.poke && edges == 1) begin
            req = 1'b1; wen = 1'b1; size = 2'b10; addr = 32'h18; wdata = 32'h11111111;
         end else req = 1'b0;
         if (mem_we) wes++;
         if (done) begin
            rd = rdata; mis = misalign; seen = 1'b1;
         end
      end
      req = 1'b0;
      if (!seen) edges = -1;
   endtask

   initial begin
      int          e, w;
      logic [31:0] r, cur10;
      logic        m;

      tv[0]  = mk(0, 2'b00, 1, 32'h11, 0, 0, 32'hFFFFFFAA, 2, 0, 0, 32'h10, 32'h8899AABB);
      tv[1]  = mk(0, 2'b01, 0, 32'h12, 0, 0, 32'h00008899, 2, 0, 0, 32'h10, 32'h8899AABB);
      tv[2]  = mk(0, 2'b01, 1, 32'h10, 0, 0, 32'hFFFFAABB, 2, 0, 0, 32'h10, 32'h8899AABB);
      tv[3]  = mk(0, 2'b00, 0, 32'h13, 0, 0, 32'h00000088, 2, 0, 0, 32'h10, 32'h8899AABB);
      tv[4]  = mk(1, 2'b01, 0, 32'h12, 32'hDEAD1234, 0, 32'h00000088, 3, 1, 0, 32'h10, 32'h1234AABB);
      tv[5]  = mk(1, 2'b00, 0, 32'h10, 32'h00000055, 0, 32'h00000088, 3, 1, 0, 32'h10, 32'h1234AA55);
      tv[6]  = mk(1, 2'b10, 0, 32'h14, 32'hCAFEF00D, 1, 32'h00000088, 2, 1, 0, 32'h14, 32'hCAFEF00D);
      tv[7]  = mk(0, 2'b10, 0, 32'h14, 0, 0, 32'hCAFEF00D, 2, 0, 0, 32'h14, 32'hCAFEF00D);
      tv[8]  = mk(0, 2'b00, 1, 32'h16, 0, 0, 32'hFFFFFFFE, 2, 0, 0, 32'h14, 32'hCAFEF00D);
      tv[9]  = mk(0, 2'b11, 1, 32'h10, 0, 0, 32'h1234AA55, 2, 0, 0, 32'h10, 32'h1234AA55);
      tv[10] = mk(1, 2'b00, 0, 32'h13, 32'h000001FF, 0, 32'h1234AA55, 3, 1, 0, 32'h10, 32'hFF34AA55);
`ifdef LSU_MISALIGN_TRAP_EN
      tv[11] = mk(0, 2'b10, 0, 32'h12, 0, 0, 32'h1234AA55, 1, 0, 1, 32'h10, 32'hFF34AA55);
      tv[12] = mk(1, 2'b01, 0, 32'h11, 32'h00007777, 0, 32'h1234AA55, 1, 0, 1, 32'h10, 32'hFF34AA55);
      tv[13] = mk(0, 2'b01, 1, 32'h13, 0, 0, 32'h1234AA55, 1, 0, 1, 32'h10, 32'hFF34AA55);
      cur10 = 32'hFF34AA55;
`else
      tv[11] = mk(0, 2'b10, 0, 32'h12, 0, 0, 32'hFF34AA55, 2, 0, 0, 32'h10, 32'hFF34AA55);
      tv[12] = mk(1, 2'b01, 0, 32'h11, 32'h00007777, 0, 32'hFF34AA55, 3, 1, 0, 32'h10, 32'hFF347777);
      tv[13] = mk(0, 2'b01, 1, 32'h13, 0, 0, 32'hFFFFFF34, 2, 0, 0, 32'h10, 32'hFF347777);
      cur10 = 32'hFF347777;
`endif

      rst_n = 1'b0; req = 1'b0; wen = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;
      pre_we = 1'b1;
      pre_idx = 6'd4; pre_val = 32'h8899AABB; @(posedge clk); #1;
      pre_idx = 6'd5; pre_val = 32'h0;        @(posedge clk); #1;
      pre_idx = 6'd6; pre_val = 32'h0;        @(posedge clk); #1;
      pre_we = 1'b0;
      @(negedge clk);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
      chk("reset mem_wd", mem_wd, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run(tv[i], e, w, r, m);
         chk($sformatf("v%0d rdata", i), r, tv[i].exp_rd);
         chk($sformatf("v%0d latency", i), 32'(e), 32'(tv[i].exp_edges));
         chk($sformatf("v%0d mem_we cycles", i), 32'(w), 32'(tv[i].exp_we));
         chk($sformatf("v%0d misalign", i), {31'd0, m}, {31'd0, tv[i].exp_mis});
         chk($sformatf("v%0d mem word", i), mem[tv[i].chk_addr[7:2]], tv[i].exp_word);
      end
      chk("ignored req word 0x18", mem[6], 32'h0);
      @(negedge clk);
      chk("idle after seq busy", {31'd0, busy}, 32'd0);

      // Reset during RD of a byte store: nothing written, all outputs cleared.
      @(negedge clk);
      req = 1'b1; wen = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h10; wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      chk("mid-RD busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async rst busy", {31'd0, busy}, 32'd0);
      chk("async rst done", {31'd0, done}, 32'd0);
      chk("async rst misalign", {31'd0, misalign}, 32'd0);
      chk("async rst mem_we", {31'd0, mem_we}, 32'd0);
      chk("async rst rdata", rdata, 32'd0);
      chk("async rst mem_wd", mem_wd, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-rst busy", {31'd0, busy}, 32'd0);
      chk("post-rst word 0x10", mem[4], cur10);
      run(mk(0, 2'b10, 0, 32'h10, 0, 0, cur10, 2, 0, 0, 32'h10, cur10), e, w, r, m);
      chk("post-rst lw rdata", r, cur10);
      chk("post-rst lw latency", 32'(e), 32'd2);
      chk("post-rst lw mem_we", 32'(w), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
